// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: lets the I-cache refill burst port, the D-cache port and the
// VPU memory port share one single-port SRAM. Round-robin arbitration in IDLE.
// An I-cache burst keeps the SRAM until its last beat is handshaken. Every output
// comes straight from a flop.
module main_mem_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ic_arvalid_i,
    input  logic [31:0]           ic_araddr_i,
    input  logic [7:0]            ic_arlen_i,
    output logic                  ic_arready_o,
    output logic                  ic_rvalid_o,
    output logic [31:0]           ic_rdata_o,
    output logic                  ic_rlast_o,
    input  logic                  ic_rready_i,
    input  logic                  dc_rd_i,
    input  logic [3:0]            dc_wr_i,
    input  logic [31:0]           dc_addr_i,
    input  logic [31:0]           dc_wdata_i,
    output logic                  dc_accept_o,
    output logic                  dc_ack_o,
    output logic [31:0]           dc_rdata_o,
    input  logic                  vp_valid_i,
    output logic                  vp_ready_o,
    input  logic [31:0]           vp_addr_i,
    input  logic [3:0]            vp_be_i,
    input  logic [31:0]           vp_wdata_i,
    input  logic [X_ID_WIDTH-1:0] vp_id_i,
    output logic                  vp_res_valid_o,
    output logic [31:0]           vp_res_rdata_o,
    output logic [X_ID_WIDTH-1:0] vp_res_id_o,
    output logic                  mem_req_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IC_RD   = 3'd1,
        IC_DATA = 3'd2,
        DC_MEM  = 3'd3,
        DC_RSP  = 3'd4,
        VP_MEM  = 3'd5,
        VP_RSP  = 3'd6
    } state_e;

    // Requester indices, also the round-robin pointer encoding.
    localparam logic [1:0] SRC_IC = 2'd0;
    localparam logic [1:0] SRC_DC = 2'd1;
    localparam logic [1:0] SRC_VP = 2'd2;

    // Returns the requester that follows src in the IC -> DC -> VP ring.
    function automatic logic [1:0] next_src(input logic [1:0] src);
        logic [1:0] nxt;
        case (src)
            SRC_IC:  nxt = SRC_DC;
            SRC_DC:  nxt = SRC_VP;
            default: nxt = SRC_IC;
        endcase
        return nxt;
    endfunction

    state_e                state_q;
    logic [1:0]            ptr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;
    logic                  op_wr_q;
    logic [X_ID_WIDTH-1:0] id_q;

    logic                  ic_arready_q, ic_rvalid_q, ic_rlast_q;
    logic [31:0]           ic_rdata_q;
    logic                  dc_accept_q, dc_ack_q;
    logic [31:0]           dc_rdata_q;
    logic                  vp_ready_q, vp_res_valid_q;
    logic [31:0]           vp_res_rdata_q;
    logic [X_ID_WIDTH-1:0] vp_res_id_q;
    logic                  mem_req_q;
    logic [3:0]            mem_be_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic [2:0]            pend_d;
    logic [1:0]            win_d;
    logic                  unused_addr_bits;

    // Byte-address bits above the SRAM window and the byte offset are ignored.
    assign unused_addr_bits = ^{ic_araddr_i[31:ADDR_W+2], ic_araddr_i[1:0],
                                dc_addr_i[31:ADDR_W+2], dc_addr_i[1:0],
                                vp_addr_i[31:ADDR_W+2], vp_addr_i[1:0]};

    // Pick the first pending requester at or after the round-robin pointer.
    always_comb begin
        pend_d = {vp_valid_i, dc_rd_i | (|dc_wr_i), ic_arvalid_i};
        win_d  = SRC_IC;
        case (ptr_q)
            SRC_IC: begin
                if (pend_d[0])      win_d = SRC_IC;
                else if (pend_d[1]) win_d = SRC_DC;
                else if (pend_d[2]) win_d = SRC_VP;
                else                win_d = SRC_IC;
            end
            SRC_DC: begin
                if (pend_d[1])      win_d = SRC_DC;
                else if (pend_d[2]) win_d = SRC_VP;
                else if (pend_d[0]) win_d = SRC_IC;
                else                win_d = SRC_DC;
            end
            SRC_VP: begin
                if (pend_d[2])      win_d = SRC_VP;
                else if (pend_d[0]) win_d = SRC_IC;
                else if (pend_d[1]) win_d = SRC_DC;
                else                win_d = SRC_VP;
            end
            default: win_d = SRC_IC;
        endcase
    end

    // Arbitration FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            ptr_q          <= SRC_IC;
            len_q          <= 8'd0;
            beat_q         <= 8'd0;
            op_wr_q        <= 1'b0;
            id_q           <= {X_ID_WIDTH{1'b0}};
            ic_arready_q   <= 1'b0;
            ic_rvalid_q    <= 1'b0;
            ic_rlast_q     <= 1'b0;
            ic_rdata_q     <= 32'd0;
            dc_accept_q    <= 1'b0;
            dc_ack_q       <= 1'b0;
            dc_rdata_q     <= 32'd0;
            vp_ready_q     <= 1'b0;
            vp_res_valid_q <= 1'b0;
            vp_res_rdata_q <= 32'd0;
            vp_res_id_q    <= {X_ID_WIDTH{1'b0}};
            mem_req_q      <= 1'b0;
            mem_be_q       <= 4'd0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_wdata_q    <= 32'd0;
        end else begin
            ic_arready_q   <= 1'b0;
            dc_accept_q    <= 1'b0;
            dc_ack_q       <= 1'b0;
            vp_ready_q     <= 1'b0;
            vp_res_valid_q <= 1'b0;
            mem_req_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pend_d) begin
                        ptr_q     <= next_src(win_d);
                        mem_req_q <= 1'b1;
                        case (win_d)
                            SRC_IC: begin
                                state_q      <= IC_RD;
                                ic_arready_q <= 1'b1;
                                mem_be_q     <= 4'd0;
                                mem_addr_q   <= ic_araddr_i[ADDR_W+1:2];
                                len_q        <= ic_arlen_i;
                                beat_q       <= 8'd0;
                            end
                            SRC_DC: begin
                                state_q     <= DC_MEM;
                                dc_accept_q <= 1'b1;
                                mem_be_q    <= dc_wr_i;
                                mem_addr_q  <= dc_addr_i[ADDR_W+1:2];
                                mem_wdata_q <= dc_wdata_i;
                                op_wr_q     <= |dc_wr_i;
                            end
                            SRC_VP: begin
                                state_q     <= VP_MEM;
                                vp_ready_q  <= 1'b1;
                                mem_be_q    <= vp_be_i;
                                mem_addr_q  <= vp_addr_i[ADDR_W+1:2];
                                mem_wdata_q <= vp_wdata_i;
                                op_wr_q     <= |vp_be_i;
                                id_q        <= vp_id_i;
                            end
                            default: begin
                                state_q <= IDLE;
                            end
                        endcase
                    end else begin
                        state_q <= IDLE;
                    end
                end
                IC_RD: begin
                    state_q <= IC_DATA;
                end
                IC_DATA: begin
                    if (!ic_rvalid_q) begin
                        // SRAM data is only valid this one cycle; hold it locally.
                        ic_rvalid_q <= 1'b1;
                        ic_rdata_q  <= mem_rdata_i;
                        ic_rlast_q  <= (beat_q == len_q);
                    end else if (ic_rready_i) begin
                        ic_rvalid_q <= 1'b0;
                        ic_rlast_q  <= 1'b0;
                        if (ic_rlast_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= IC_RD;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            beat_q     <= beat_q + 8'd1;
                        end
                    end else begin
                        state_q <= IC_DATA;
                    end
                end
                DC_MEM: begin
                    mem_be_q <= 4'd0;
                    state_q  <= DC_RSP;
                end
                DC_RSP: begin
                    dc_ack_q   <= 1'b1;
                    dc_rdata_q <= op_wr_q ? 32'd0 : mem_rdata_i;
                    state_q    <= IDLE;
                end
                VP_MEM: begin
                    mem_be_q <= 4'd0;
                    state_q  <= VP_RSP;
                end
                VP_RSP: begin
                    vp_res_valid_q <= 1'b1;
                    vp_res_id_q    <= id_q;
                    vp_res_rdata_q <= op_wr_q ? 32'd0 : mem_rdata_i;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ic_arready_o   = ic_arready_q;
    assign ic_rvalid_o    = ic_rvalid_q;
    assign ic_rdata_o     = ic_rdata_q;
    assign ic_rlast_o     = ic_rlast_q;
    assign dc_accept_o    = dc_accept_q;
    assign dc_ack_o       = dc_ack_q;
    assign dc_rdata_o     = dc_rdata_q;
    assign vp_ready_o     = vp_ready_q;
    assign vp_res_valid_o = vp_res_valid_q;
    assign vp_res_rdata_o = vp_res_rdata_q;
    assign vp_res_id_o    = vp_res_id_q;
    assign mem_req_o      = mem_req_q;
    assign mem_be_o       = mem_be_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed and randomized bench for main_mem_arbiter. An SRAM
// model answers the memory port. A reference memory and a round-robin pointer model
// give the expected read data and service order.
module tb_main_mem_arbiter;
    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ic_arvalid_i = 1'b0, ic_rready_i = 1'b0;
    logic [31:0] ic_araddr_i = 32'd0;
    logic [7:0]  ic_arlen_i = 8'd0;
    logic        ic_arready_o, ic_rvalid_o, ic_rlast_o;
    logic [31:0] ic_rdata_o;
    logic        dc_rd_i = 1'b0;
    logic [3:0]  dc_wr_i = 4'd0;
    logic [31:0] dc_addr_i = 32'd0, dc_wdata_i = 32'd0;
    logic        dc_accept_o, dc_ack_o;
    logic [31:0] dc_rdata_o;
    logic        vp_valid_i = 1'b0;
    logic        vp_ready_o;
    logic [31:0] vp_addr_i = 32'd0, vp_wdata_i = 32'd0;
    logic [3:0]  vp_be_i = 4'd0, vp_id_i = 4'd0;
    logic        vp_res_valid_o;
    logic [31:0] vp_res_rdata_o;
    logic [3:0]  vp_res_id_o;
    logic        mem_req_o;
    logic [3:0]  mem_be_o;
    logic [12:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;

    main_mem_arbiter #(.ADDR_W(13), .X_ID_WIDTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .ic_arvalid_i(ic_arvalid_i), .ic_araddr_i(ic_araddr_i), .ic_arlen_i(ic_arlen_i),
        .ic_arready_o(ic_arready_o), .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
        .ic_rlast_o(ic_rlast_o), .ic_rready_i(ic_rready_i),
        .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_accept_o(dc_accept_o), .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
        .vp_valid_i(vp_valid_i), .vp_ready_o(vp_ready_o), .vp_addr_i(vp_addr_i),
        .vp_be_i(vp_be_i), .vp_wdata_i(vp_wdata_i), .vp_id_i(vp_id_i),
        .vp_res_valid_o(vp_res_valid_o), .vp_res_rdata_o(vp_res_rdata_o), .vp_res_id_o(vp_res_id_o),
        .mem_req_o(mem_req_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int mreq_cnt = 0;
    int arready_cnt = 0;
    int order_q[$];
    int mdl_ptr = 0;
    logic [31:0] sram [DEPTH] = '{default: 32'd0};
    logic [31:0] ref_mem [DEPTH] = '{default: 32'd0};
    logic        bd_we = 1'b0;
    logic [12:0] bd_addr = 13'd0;
    logic [31:0] bd_data = 32'd0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[14:2]);
    endfunction

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: read data one cycle after a read strobe, garbage otherwise; backdoor preload.
    always @(posedge clk) begin
        if (mem_req_o && mem_be_o == 4'd0) mem_rdata_i <= sram[mem_addr_o];
        else mem_rdata_i <= $urandom;
        if (bd_we) sram[bd_addr] <= bd_data;
        else if (mem_req_o && mem_be_o != 4'd0) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
    end

    // Monitor: count SRAM strobes and accept pulses, log the service order.
    always @(negedge clk) begin
        if (mem_req_o) mreq_cnt <= mreq_cnt + 1;
        if (ic_arready_o) arready_cnt <= arready_cnt + 1;
        if (ic_arready_o) order_q.push_back(0);
        if (dc_accept_o) order_q.push_back(1);
        if (vp_ready_o) order_q.push_back(2);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {ic_arready_o, ic_rvalid_o, ic_rdata_o, ic_rlast_o, dc_accept_o, dc_ack_o,
                  dc_rdata_o, vp_ready_o, vp_res_valid_o, vp_res_rdata_o, vp_res_id_o,
                  mem_req_o, mem_be_o, mem_addr_o, mem_wdata_o}, 256'd0);
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = w[12:0]; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[w] = d;
    endtask

    task automatic ic_burst(input logic [31:0] addr, input logic [7:0] len);
        int t, b, w;
        w = widx(addr);
        ic_arvalid_i = 1'b1; ic_araddr_i = addr; ic_arlen_i = len; ic_rready_i = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ic_arready_o && t < 200);
        chk("ic_arready", ic_arready_o, 1'b1);
        ic_arvalid_i = 1'b0;
        mdl_ptr = 1;
        b = 0; t = 0;
        while (b <= int'(len) && t < 2000) begin
            @(negedge clk); t++;
            if (ic_rvalid_o) begin
                chk("ic_rdata", ic_rdata_o, ref_mem[(w + b) % DEPTH]);
                chk("ic_rlast", ic_rlast_o, (b == int'(len)));
                b++;
            end
        end
        chk("ic_beats", b, int'(len) + 1);
    endtask

    task automatic dc_access(input logic [3:0] wr, input logic [31:0] addr, input logic [31:0] wdata,
                             output int acc, output logic [31:0] rd);
        int t;
        dc_rd_i = (wr == 4'd0); dc_wr_i = wr; dc_addr_i = addr; dc_wdata_i = wdata;
        t = 0;
        do begin @(negedge clk); t++; end while (!dc_accept_o && t < 200);
        chk("dc_accept", dc_accept_o, 1'b1);
        acc = cyc;
        dc_rd_i = 1'b0; dc_wr_i = 4'd0;
        mdl_ptr = 2;
        @(negedge clk);
        chk("dc_accept_pulse", dc_accept_o, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (!dc_ack_o && t < 20);
        chk("dc_ack", dc_ack_o, 1'b1);
        chk("dc_latency", cyc - acc, 2);
        rd = dc_rdata_o;
        if (wr == 4'd0) chk("dc_rdata", rd, ref_mem[widx(addr)]);
        else ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], wdata, wr);
    endtask

    task automatic vp_access(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] id, output logic [31:0] rd);
        int t;
        vp_valid_i = 1'b1; vp_be_i = be; vp_addr_i = addr; vp_wdata_i = wdata; vp_id_i = id;
        t = 0;
        do begin @(negedge clk); t++; end while (!vp_ready_o && t < 200);
        chk("vp_ready", vp_ready_o, 1'b1);
        vp_valid_i = 1'b0;
        mdl_ptr = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!vp_res_valid_o && t < 20);
        chk("vp_res_valid", vp_res_valid_o, 1'b1);
        chk("vp_res_id", vp_res_id_o, id);
        rd = vp_res_rdata_o;
        if (be == 4'd0) chk("vp_rdata", rd, ref_mem[widx(addr)]);
        else begin
            chk("vp_wr_rdata_zero", rd, 32'd0);
            ref_mem[widx(addr)] = merge(ref_mem[widx(addr)], wdata, be);
        end
        @(negedge clk);
        chk("vp_res_pulse", vp_res_valid_o, 1'b0);
    endtask

    // All requesters in mask m raise their request in the same cycle.
    task automatic round(input logic [2:0] m, output int base);
        int exp_ord[$];
        int s, acc, obs;
        logic [31:0] ia, da, va, dd, vd, rd1, rd2;
        logic [7:0]  il;
        logic [3:0]  dw, vb, vi;
        ia = $urandom; il = 8'($urandom_range(0, 3));
        da = $urandom; dd = $urandom; dw = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        va = $urandom; vd = $urandom; vb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        vi = 4'($urandom);
        for (int k = 0; k <= int'(il); k++) poke((widx(ia) + k) % DEPTH, $urandom);
        poke(widx(da), $urandom);
        poke(widx(va), $urandom);
        for (int k = 0; k < 3; k++) begin
            s = (mdl_ptr + k) % 3;
            if (m[s]) exp_ord.push_back(s);
        end
        base = order_q.size();
        fork
            begin if (m[0]) ic_burst(ia, il); end
            begin if (m[1]) dc_access(dw, da, dd, acc, rd1); end
            begin if (m[2]) vp_access(vb, va, vd, vi, rd2); end
        join
        chk("rr_count", order_q.size() - base, exp_ord.size());
        foreach (exp_ord[k]) begin
            obs = (base + k < order_q.size()) ? order_q[base + k] : -1;
            chk("rr_order", obs, exp_ord[k]);
        end
    endtask

    initial begin
        int t, b, m0, a0, acc, last_cyc, base;
        logic [31:0] rd, held;
        logic stalled;

        // Reset with requests applied: nothing may leave the block.
        ic_arvalid_i = 1'b1; dc_rd_i = 1'b1; vp_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        ic_arvalid_i = 1'b0; dc_rd_i = 1'b0; vp_valid_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        mdl_ptr = 0;
        @(negedge clk);
        chk_zero("post_release_idle");

        // Simultaneous requests right after reset, twice: IC, DC, VP each time.
        for (int r = 0; r < 2; r++) begin
            round(3'b111, base);
            chk("all3_first_ic", order_q[base], 0);
            chk("all3_second_dc", order_q[base + 1], 1);
            chk("all3_third_vp", order_q[base + 2], 2);
        end

        // Four-beat burst at 0x40.
        poke(16, 32'hA0A0A0A0); poke(17, 32'hB1B1B1B1); poke(18, 32'hC2C2C2C2); poke(19, 32'hD3D3D3D3);
        m0 = mreq_cnt; a0 = arready_cnt;
        ic_burst(32'h0000_0040, 8'd3);
        chk("ic4_mem_reads", mreq_cnt - m0, 4);
        chk("ic4_arready_pulses", arready_cnt - a0, 1);

        // Partial D-cache write then read back.
        poke(64, 32'h11223344);
        dc_access(4'b0011, 32'h0000_0100, 32'hAABBCCDD, acc, rd);
        dc_access(4'b0000, 32'h0000_0100, 32'd0, acc, rd);
        chk("dc_merge", rd, 32'h1122CCDD);

        // VPU read with id 5.
        poke(128, 32'hCAFEF00D);
        vp_access(4'd0, 32'h0000_0200, 32'd0, 4'd5, rd);
        chk("vp_cafe_data", rd, 32'hCAFEF00D);
        chk("vp_cafe_id", vp_res_id_o, 4'd5);

        // Burst wrapping from the top word to word 0, high address bits ignored.
        poke(8191, $urandom); poke(0, $urandom);
        ic_burst(32'hABCD_7FFC, 8'd1);

        // Burst stalled on beat 1 while the D-cache asks for the memory.
        poke(192, $urandom); poke(193, $urandom); poke(194, $urandom); poke(256, $urandom);
        m0 = mreq_cnt; last_cyc = 0; stalled = 1'b0;
        ic_arvalid_i = 1'b1; ic_araddr_i = 32'h0000_0300; ic_arlen_i = 8'd2; ic_rready_i = 1'b1;
        fork
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!ic_arready_o && t < 200);
                chk("stall_arready", ic_arready_o, 1'b1);
                ic_arvalid_i = 1'b0;
                mdl_ptr = 1;
                b = 0; t = 0;
                while (b <= 2 && t < 200) begin
                    @(negedge clk); t++;
                    if (ic_rvalid_o) begin
                        if (b == 1 && !stalled) begin
                            ic_rready_i = 1'b0;
                            held = ic_rdata_o;
                            repeat (3) begin
                                @(negedge clk);
                                chk("stall_rvalid_held", ic_rvalid_o, 1'b1);
                                chk("stall_rdata_held", ic_rdata_o, held);
                                chk("stall_no_mem_req", mem_req_o, 1'b0);
                                chk("stall_no_dc_accept", dc_accept_o, 1'b0);
                            end
                            ic_rready_i = 1'b1;
                            stalled = 1'b1;
                        end
                        chk("stall_rdata", ic_rdata_o, ref_mem[192 + b]);
                        chk("stall_rlast", ic_rlast_o, (b == 2));
                        if (b == 2) last_cyc = cyc;
                        b++;
                    end
                end
                chk("stall_beats", b, 3);
                chk("stall_mem_reads", mreq_cnt - m0, 3);
            end
            begin
                repeat (4) @(negedge clk);
                dc_access(4'd0, 32'h0000_0400, 32'd0, acc, rd);
            end
        join
        chk("dc_after_rlast", acc, last_cyc + 2);

        // Reset in the middle of a burst, then a VPU write/read completes normally.
        ic_arvalid_i = 1'b1; ic_araddr_i = $urandom; ic_arlen_i = 8'd7; ic_rready_i = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!ic_arready_o && t < 200);
        ic_arvalid_i = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!ic_rvalid_o && t < 20);
        chk("midburst_rvalid", ic_rvalid_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk_zero("async_reset_outputs");
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        mdl_ptr = 0;
        ic_rready_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_partial_response", {ic_rvalid_o, ic_rlast_o, mem_req_o, dc_ack_o, vp_res_valid_o}, 5'd0);
        end
        poke(300, 32'h0F0F0F0F);
        vp_access(4'b1111, 32'h0000_04B0, 32'h5A5AA5A5, 4'd9, rd);
        vp_access(4'b0000, 32'h0000_04B0, 32'd0, 4'd3, rd);
        chk("post_reset_vp_write", rd, 32'h5A5AA5A5);

        // Randomized traffic against the reference memory and round-robin model.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rdat;
            logic [7:0]  rl;
            logic [3:0]  rbe;
            ra = $urandom; rdat = $urandom;
            rbe = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            case ($urandom_range(0, 3))
                0: begin
                    rl = 8'($urandom_range(0, 4));
                    for (int k = 0; k <= int'(rl); k++) poke((widx(ra) + k) % DEPTH, $urandom);
                    ic_burst(ra, rl);
                end
                1: begin
                    poke(widx(ra), $urandom);
                    dc_access(rbe, ra, rdat, acc, rd);
                end
                2: begin
                    poke(widx(ra), $urandom);
                    vp_access(rbe, ra, rdat, 4'($urandom), rd);
                end
                default: round(3'($urandom_range(1, 7)), base);
            endcase
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
